// File: rtl/char_ram_16x16_ctl.sv
// -----------------------------------------------------------------------------
// char_ram_16x16_ctl
//
// Writable 16x16 character buffer. This block takes the place of the fixed
// character ROM in front of font_rom. A byte stream arrives over a valid/ready
// handshake and is interpreted like a simple terminal: printable characters,
// CR/LF, backspace, tab and form-feed. The block stores 7-bit character codes
// in a 256-entry RAM addressed {row, col}. The pixel pipeline reads the RAM
// through char_xy, and char_code comes back one cycle later.
//
// Ports
//   pclk        in   1  pixel clock; all logic on the rising edge
//   rst         in   1  synchronous active-high reset
//   data_in     in   8  incoming byte
//   data_valid  in   1  data_in is valid
//   data_ready  out  1  a byte can be accepted this cycle
//   char_xy     in   8  read address {row, col}
//   char_code   out  7  registered character code at char_xy
//   cursor_xy   out  8  current write position {row, col}
//   busy        out  1  clear sequence in progress
// -----------------------------------------------------------------------------
module char_ram_16x16_ctl #(
    parameter logic [6:0] CLR_CHAR = 7'h20,
    parameter int         TAB_W    = 4
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic [7:0] cursor_xy,
    output logic       busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Clearing the low bits of the column snaps it to the current tab stop.
    localparam logic [3:0] TAB_MASK = 4'(TAB_W - 1);
    localparam logic [4:0] TAB_STEP = 5'(TAB_W);

    state_t     state_q, state_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic [7:0] cursor_q, cursor_d;
    logic [6:0] char_code_q;

    logic [6:0] mem [0:255];

    logic       wr_en;
    logic [7:0] wr_addr;
    logic [6:0] wr_data;

    logic       accept;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] row_inc;
    logic [4:0] tab_col;
    logic       printable;

    assign row       = cursor_q[7:4];
    assign col       = cursor_q[3:0];
    assign row_inc   = row + 4'd1;
    assign tab_col   = {1'b0, col & ~TAB_MASK} + TAB_STEP;
    assign printable = (data_in[6:0] >= 7'h20) && (data_in[6:0] <= 7'h7E);
    assign accept    = data_valid && data_ready;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= 8'd0;
            cursor_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cursor_q  <= cursor_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // Also produces the single RAM write for this cycle: either the clear sweep
    // or the effect of the byte being accepted.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cursor_d  = cursor_q;
        wr_en     = 1'b0;
        wr_addr   = cursor_q;
        wr_data   = data_in[6:0];

        case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = CLR_CHAR;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                // Bytes with bit 7 set are consumed without any effect.
                if (accept && !data_in[7]) begin
                    if (printable) begin
                        wr_en    = 1'b1;
                        // {row,col}+1 wraps col into row and row 15 into 0.
                        cursor_d = cursor_q + 8'd1;
                    end else begin
                        case (data_in[6:0])
                            7'h0A, 7'h0D: begin
                                cursor_d = {row_inc, 4'd0};
                            end
                            7'h09: begin
                                if (tab_col >= 5'd16) begin
                                    cursor_d = {row_inc, 4'd0};
                                end else begin
                                    cursor_d = {row, tab_col[3:0]};
                                end
                            end
                            7'h08: begin
                                if (cursor_q != 8'd0) begin
                                    cursor_d = cursor_q - 8'd1;
                                    wr_en    = 1'b1;
                                    wr_addr  = cursor_q - 8'd1;
                                    wr_data  = CLR_CHAR;
                                end
                            end
                            7'h0C: begin
                                cursor_d  = 8'd0;
                                clr_cnt_d = 8'd0;
                                state_d   = ST_CLEAR;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Reset forces the not-ready/busy view immediately, whatever state holds.
    always_comb begin
        data_ready = (state_q == ST_IDLE) && !rst;
        busy       = !data_ready;
    end

    // ---------------------------------------------------------------- RAM
    always_ff @(posedge pclk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read. A read of the address being written in the same cycle
    // returns the old contents.
    always_ff @(posedge pclk) begin
        if (rst) begin
            char_code_q <= 7'd0;
        end else begin
            char_code_q <= mem[char_xy];
        end
    end

    assign char_code = char_code_q;
    assign cursor_xy = cursor_q;

endmodule
